// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings, frame
// header byte, error codes and the length-check helper.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_e;

    localparam logic [7:0] LOADER_HDR = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // A word count is usable when it is non-zero and fits the RAM image.
    function automatic logic len_ok(input logic [7:0] n, input int unsigned ram_size);
        return (n != 8'd0) && (32'(n) <= ram_size);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake between a byte source (UART RX, bench) and the
// loader. A byte transfers on a cycle where rx_valid and rx_ready are both 1.
interface program_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs four bytes (most significant first) into a 32-bit word. Only the
// first three bytes are stored; the fourth is taken straight from the input
// so the completed word is available in the same cycle as word_done, which
// lets the loader write RAM and change state on that same byte.
module program_loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // Next value of the byte shift register and byte counter.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = 24'd0;
            cnt_d   = 2'd0;
        end else if (strobe) begin
            shift_d = {shift_q[15:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // Shift register and byte counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= 24'd0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word      = {shift_q, byte_in};
    assign word_done = strobe && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Byte-stream boot loader. Accepts a frame 0xA5 | N | N*4 data bytes (MSB
// first) | sum(data) mod 256, builds the flat RAM image for the CPU and holds
// the CPU in reset until a frame with a good checksum has been received.
// Optional feature macro: LOADER_TIMEOUT_EN (inter-byte timeout, err_code 3).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int RAM_SIZE       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    program_loader_if.slave         rx,
    output logic [RAM_SIZE*32-1:0]  ram,
    output logic                    cpu_reset,
    output logic                    load_done,
    output logic                    load_err,
    output logic [1:0]              err_code
);

    loader_state_e state_q, state_d;
    logic [1:0]    err_set_s;

    logic [RAM_SIZE-1:0][31:0] ram_q, ram_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    word_idx_q, word_idx_d;
    logic [7:0]    n_q, n_d;

    logic          cpu_reset_q, cpu_reset_d;
    logic          load_done_q, load_done_d;
    logic          load_err_q, load_err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic          rx_ready_s;
    logic          accept_s;
    logic          is_hdr_s;
    logic          last_word_s;
    logic          timeout_hit_s;
    logic [31:0]   asm_word_s;
    logic          asm_done_s;

    assign rx_ready_s  = (state_q != ST_CLEAR);
    assign rx.rx_ready = rx_ready_s;
    assign accept_s    = rx.rx_valid && rx_ready_s;
    assign is_hdr_s    = (rx.rx_data == LOADER_HDR);
    assign last_word_s = (word_idx_q == (n_q - 8'd1));

    program_loader_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (rx.rx_data),
        .strobe    (accept_s && (state_q == ST_DATA)),
        .clear     (state_q == ST_CLEAR),
        .word      (asm_word_s),
        .word_done (asm_done_s)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        waiting_s;

    // Waiting for the next byte of a frame that has already started.
    assign waiting_s     = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign timeout_hit_s = waiting_s && !accept_s &&
                           ((idle_cnt_q + 16'd1) == 16'(TIMEOUT_CYCLES));

    // Idle counter: counts byte-less cycles mid-frame, restarts on any byte.
    always_comb begin
        idle_cnt_d = 16'd0;
        if (waiting_s && !accept_s) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end else begin
            idle_cnt_d = 16'd0;
        end
    end

    // Idle counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= 16'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic timeout_param_unused;

    // Without the timeout the loader waits forever for the next byte.
    assign timeout_hit_s        = 1'b0;
    assign timeout_param_unused = (TIMEOUT_CYCLES == 0);
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; err_set_s is the code to record when entering ERR.
    always_comb begin
        state_d   = state_q;
        err_set_s = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_hdr_s) state_d = ST_CLEAR;
                else                      state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                state_d = ST_LEN;
            end
            ST_LEN: begin
                if (accept_s) begin
                    if (len_ok(rx.rx_data, RAM_SIZE)) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d   = ST_ERR;
                        err_set_s = ERR_LEN;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (accept_s && asm_done_s && last_word_s) state_d = ST_CSUM;
                else                                       state_d = ST_DATA;
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (rx.rx_data == csum_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d   = ST_ERR;
                        err_set_s = ERR_CSUM;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_RUN, ST_ERR: begin
                if (accept_s && is_hdr_s) state_d = ST_CLEAR;
                else                      state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout_hit_s) begin
            state_d   = ST_ERR;
            err_set_s = ERR_TIMEOUT;
        end else begin
            state_d   = state_d;
        end
    end

    // FSM outputs, computed from the next state so they change on the same
    // edge that accepts the deciding byte.
    always_comb begin
        cpu_reset_d = (state_d != ST_RUN);
        load_done_d = (state_d == ST_RUN);
        load_err_d  = (state_d == ST_ERR);
        err_code_d  = err_code_q;
        if (state_d == ST_CLEAR) begin
            err_code_d = ERR_NONE;
        end else if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            err_code_d = err_set_s;
        end else begin
            err_code_d = err_code_q;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Datapath: RAM image, checksum, word index and latched word count.
    always_comb begin
        ram_d      = ram_q;
        csum_d     = csum_q;
        word_idx_d = word_idx_q;
        n_d        = n_q;
        if (state_q == ST_CLEAR) begin
            ram_d      = '0;
            csum_d     = 8'd0;
            word_idx_d = 8'd0;
        end else if (accept_s && (state_q == ST_LEN)) begin
            n_d = rx.rx_data;
        end else if (accept_s && (state_q == ST_DATA)) begin
            csum_d = csum_q + rx.rx_data;
            if (asm_done_s) begin
                for (int i = 0; i < RAM_SIZE; i++) begin
                    if (word_idx_q == 8'(i)) ram_d[i] = asm_word_s;
                end
                word_idx_d = word_idx_q + 8'd1;
            end else begin
                word_idx_d = word_idx_q;
            end
        end else begin
            ram_d = ram_q;
        end
    end

    // Datapath state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_q      <= '0;
            csum_q     <= 8'd0;
            word_idx_q <= 8'd0;
            n_q        <= 8'd0;
        end else begin
            ram_q      <= ram_d;
            csum_q     <= csum_d;
            word_idx_q <= word_idx_d;
            n_q        <= n_d;
        end
    end

    assign ram       = ram_q;
    assign cpu_reset = cpu_reset_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader (RAM_SIZE=16, TIMEOUT_CYCLES=8).
module tb_program_loader;

    localparam int RAM_SIZE = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [RAM_SIZE*32-1:0] ram;
    logic cpu_reset, load_done, load_err;
    logic [1:0] err_code;
    int n_cmp = 0;
    int n_err = 0;

    program_loader_if rx_if ();

    program_loader #(.RAM_SIZE(RAM_SIZE), .TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx_if.slave),
        .ram       (ram),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_at(input int i);
        return ram[i*32 +: 32];
    endfunction

    // Present one byte from a negedge and hold it until accepted.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        @(negedge clk);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = b;
        guard = 0;
        while (!rx_if.rx_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 10) begin
            $display("FAIL send_byte: rx_ready stuck 0, byte %h not accepted", b);
            n_err++;
        end
        @(posedge clk);
        #1;
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic check_status(input string name, input logic exp_rst, input logic exp_done,
                                input logic exp_err, input logic [1:0] exp_code);
        n_cmp++;
        if ({cpu_reset, load_done, load_err, err_code} !== {exp_rst, exp_done, exp_err, exp_code}) begin
            $display("FAIL %s: rst/done/err/code got %b%b%b/%0d want %b%b%b/%0d", name,
                     cpu_reset, load_done, load_err, err_code, exp_rst, exp_done, exp_err, exp_code);
            n_err++;
        end
    endtask

    task automatic check_word(input string name, input int i, input logic [31:0] exp);
        n_cmp++;
        if (word_at(i) !== exp) begin
            $display("FAIL %s: ram w%0d got %h want %h", name, i, word_at(i), exp);
            n_err++;
        end
    endtask

    task automatic check_ram_zero_from(input string name, input int first);
        for (int i = first; i < RAM_SIZE; i++) check_word(name, i, 32'h0);
    endtask

    task automatic test_reset();
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_status("reset_status", 1'b1, 1'b0, 1'b0, 2'd0);
        n_cmp++;
        if (rx_if.rx_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b want 1", rx_if.rx_ready);
            n_err++;
        end
        check_ram_zero_from("reset_ram", 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_garbage_backpressure();
        int zero_cycles;
        send_byte(8'h00);
        send_byte(8'hFF);
        check_status("garbage_ignored", 1'b1, 1'b0, 1'b0, 2'd0);
        // header then length held on the bus straight through CLEAR
        @(negedge clk);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = 8'hA5;
        @(posedge clk);
        #1;
        rx_if.rx_data = 8'h02;
        zero_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!rx_if.rx_ready) zero_cycles++;
            else break;
        end
        n_cmp++;
        if (zero_cycles != 1) begin
            $display("FAIL clear_backpressure: rx_ready low %0d cycles want 1", zero_cycles);
            n_err++;
        end
        @(posedge clk);
        #1;
        rx_if.rx_valid = 1'b0;
        send_word(32'h01020304);
        send_word(32'h05060708);
        send_byte(8'h24);                   // 1+2+...+8 = 36
        check_status("backpressure_load", 1'b0, 1'b1, 1'b0, 2'd0);
        check_word("backpressure_w0", 0, 32'h01020304);
        check_word("backpressure_w1", 1, 32'h05060708);
    endtask

    task automatic test_good_load();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_word(32'h11223344);
        send_word(32'hAABBCCDD);
        check_status("good_before_csum", 1'b1, 1'b0, 1'b0, 2'd0);
        send_byte(8'hB8);                   // 0x3B8 mod 256
        check_status("good_after_csum", 1'b0, 1'b1, 1'b0, 2'd0);
        check_word("good_w0", 0, 32'h11223344);
        check_word("good_w1", 1, 32'hAABBCCDD);
        check_ram_zero_from("good_rest", 2);
        send_byte(8'h37);
        check_status("run_ignores_byte", 1'b0, 1'b1, 1'b0, 2'd0);
    endtask

    task automatic test_reload();
        send_byte(8'hA5);
        check_status("reload_hdr", 1'b1, 1'b0, 1'b0, 2'd0);
        send_byte(8'h01);
        send_word(32'hDEADBEEF);
        send_byte(8'h38);                   // 0x338 mod 256
        check_status("reload_run", 1'b0, 1'b1, 1'b0, 2'd0);
        check_word("reload_w0", 0, 32'hDEADBEEF);
        check_word("reload_w1", 1, 32'h0);
    endtask

    task automatic test_bad_csum();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_word(32'h11223344);
        send_word(32'hAABBCCDD);
        send_byte(8'hB9);
        check_status("bad_csum", 1'b1, 1'b0, 1'b1, 2'd2);
        check_word("bad_csum_partial_w1", 1, 32'hAABBCCDD);
    endtask

    task automatic test_bad_len();
        send_byte(8'hA5);
        check_status("err_cleared_on_hdr", 1'b1, 1'b0, 1'b0, 2'd0);
        send_byte(8'h00);
        check_status("bad_len_zero", 1'b1, 1'b0, 1'b1, 2'd1);
        check_ram_zero_from("bad_len_zero_ram", 0);
        send_byte(8'hA5);
        send_byte(8'(RAM_SIZE + 1));
        check_status("bad_len_big", 1'b1, 1'b0, 1'b1, 2'd1);
        check_ram_zero_from("bad_len_big_ram", 0);
    endtask

    task automatic test_max_len();
        send_byte(8'hA5);
        send_byte(8'(RAM_SIZE));
        for (int i = 0; i < RAM_SIZE; i++) send_word({4{8'(i)}});
        send_byte(8'hE0);                   // 4*(0+..+15) = 480 mod 256
        check_status("max_len_run", 1'b0, 1'b1, 1'b0, 2'd0);
        check_word("max_len_w0", 0, 32'h00000000);
        check_word("max_len_w9", 9, 32'h09090909);
        check_word("max_len_w15", RAM_SIZE - 1, 32'h0F0F0F0F);
    endtask

    task automatic test_async_reset();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_word(32'hCAFEF00D);
        send_byte(8'h12);
        check_word("mid_data_w0", 0, 32'hCAFEF00D);
        #2;
        reset = 1'b0;
        #1;
        check_status("async_reset_status", 1'b1, 1'b0, 1'b0, 2'd0);
        check_ram_zero_from("async_reset_ram", 0);
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_word(32'h00000001);
        send_byte(8'h01);
        check_status("after_reset_load", 1'b0, 1'b1, 1'b0, 2'd0);
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h03);
`ifdef LOADER_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 8) check_status("timeout_pending", 1'b1, 1'b0, 1'b0, 2'd0);
            else       check_status("timeout_fired", 1'b1, 1'b0, 1'b1, 2'd3);
        end
`else
        repeat (20) @(posedge clk);
        #1;
        check_status("no_timeout_wait", 1'b1, 1'b0, 1'b0, 2'd0);
        send_word(32'h00000002);
        send_word(32'h00000003);
        send_word(32'h00000004);
        send_byte(8'h09);
        check_status("no_timeout_late_load", 1'b0, 1'b1, 1'b0, 2'd0);
`endif
    endtask

    initial begin
        test_reset();
        test_garbage_backpressure();
        test_good_load();
        test_reload();
        test_bad_csum();
        test_bad_len();
        test_max_len();
        test_async_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
